// File: rtl/maze_pkg.sv
// Shared maze constants, direction bit indices and the player controller state encoding.
package maze_pkg;

   localparam int unsigned DEF_GRID_W = 24;
   localparam int unsigned DEF_GRID_H = 24;
   localparam int unsigned CELL_PITCH = 10;
   localparam int unsigned X_OFFSET   = 80;

   localparam int unsigned DIR_UP    = 0;
   localparam int unsigned DIR_DOWN  = 1;
   localparam int unsigned DIR_LEFT  = 2;
   localparam int unsigned DIR_RIGHT = 3;

   typedef enum logic [3:0] {
      StInitSetup,
      StInitDraw,
      StIdle,
      StLookup,
      StWait,
      StEval,
      StErSetup,
      StErRun,
      StGap1,
      StDrSetup,
      StDrRun,
      StGap2,
      StWon
   } state_e;

endpackage

// File: rtl/move_target_calc.sv
// Combinational target-cell calculator: position plus one-hot direction gives the
// neighbouring cell, an off-grid flag and the maze ROM address of that cell.
module move_target_calc
   import maze_pkg::*;
#(
   parameter int unsigned GRID_W = DEF_GRID_W,
   parameter int unsigned GRID_H = DEF_GRID_H
) (
   input  logic [4:0] pos_x,
   input  logic [4:0] pos_y,
   input  logic [3:0] dir,
   output logic       single,
   output logic       off_grid,
   output logic [4:0] tgt_x,
   output logic [4:0] tgt_y,
   output logic [9:0] tgt_addr
);

   always_comb begin
      single   = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
      off_grid = 1'b0;
      tgt_x    = pos_x;
      tgt_y    = pos_y;
      // Edge test precedes the step so a 5-bit wrap can never produce a target.
      if (single) begin
         if (dir[DIR_UP]) begin
            off_grid = (pos_y == 5'd0);
            if (!off_grid) tgt_y = pos_y - 5'd1;
         end else if (dir[DIR_DOWN]) begin
            off_grid = (pos_y == 5'(GRID_H - 1));
            if (!off_grid) tgt_y = pos_y + 5'd1;
         end else if (dir[DIR_LEFT]) begin
            off_grid = (pos_x == 5'd0);
            if (!off_grid) tgt_x = pos_x - 5'd1;
         end else begin
            off_grid = (pos_x == 5'(GRID_W - 1));
            if (!off_grid) tgt_x = pos_x + 5'd1;
         end
      end
      tgt_addr = 10'(tgt_y) * 10'(GRID_W) + 10'(tgt_x);
   end

endmodule

// File: rtl/player_move_ctrl.sv
// Player move controller: validates direction requests against the maze ROM and
// sequences erase/draw jobs on the box draw engine, tracking position, moves and win.
module player_move_ctrl
   import maze_pkg::*;
#(
   parameter int unsigned GRID_W  = DEF_GRID_W,
   parameter int unsigned GRID_H  = DEF_GRID_H,
   parameter int unsigned START_X = 0,
   parameter int unsigned START_Y = 1,
   parameter int unsigned EXIT_X  = 23,
   parameter int unsigned EXIT_Y  = 22
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] move_req,
   output logic [9:0] rom_addr,
   input  logic       rom_q,
   output logic       box_go,
   output logic       box_erase,
   output logic [4:0] box_x,
   output logic [4:0] box_y,
   input  logic       box_done,
   output logic [4:0] pos_x,
   output logic [4:0] pos_y,
   output logic       busy,
   output logic       bump,
   output logic       win,
   output logic [9:0] move_cnt
);

   state_e     state_q, state_d;
   logic [4:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [4:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
   logic [4:0] box_x_q, box_x_d, box_y_q, box_y_d;
   logic       box_erase_q, box_erase_d;
   logic [9:0] rom_addr_q, rom_addr_d;
   logic [9:0] move_cnt_q, move_cnt_d;
   logic       bump_q, bump_d, win_q, win_d;

   logic       req_single, req_off_grid;
   logic [4:0] calc_x, calc_y;
   logic [9:0] calc_addr;

   move_target_calc #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_calc (
      .pos_x    (pos_x_q),
      .pos_y    (pos_y_q),
      .dir      (move_req),
      .single   (req_single),
      .off_grid (req_off_grid),
      .tgt_x    (calc_x),
      .tgt_y    (calc_y),
      .tgt_addr (calc_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StInitSetup;
         pos_x_q     <= 5'(START_X);
         pos_y_q     <= 5'(START_Y);
         tgt_x_q     <= 5'(START_X);
         tgt_y_q     <= 5'(START_Y);
         box_x_q     <= 5'(START_X);
         box_y_q     <= 5'(START_Y);
         box_erase_q <= 1'b0;
         rom_addr_q  <= 10'd0;
         move_cnt_q  <= 10'd0;
         bump_q      <= 1'b0;
         win_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         tgt_x_q     <= tgt_x_d;
         tgt_y_q     <= tgt_y_d;
         box_x_q     <= box_x_d;
         box_y_q     <= box_y_d;
         box_erase_q <= box_erase_d;
         rom_addr_q  <= rom_addr_d;
         move_cnt_q  <= move_cnt_d;
         bump_q      <= bump_d;
         win_q       <= win_d;
      end
   end

   // Job coordinates are loaded on entry to each SETUP state so they are stable
   // for a full cycle before the engine sees box_go rise.
   always_comb begin
      state_d     = state_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      tgt_x_d     = tgt_x_q;
      tgt_y_d     = tgt_y_q;
      box_x_d     = box_x_q;
      box_y_d     = box_y_q;
      box_erase_d = box_erase_q;
      rom_addr_d  = rom_addr_q;
      move_cnt_d  = move_cnt_q;
      bump_d      = 1'b0;
      win_d       = win_q;
      unique case (state_q)
         StInitSetup: begin
            box_x_d     = pos_x_q;
            box_y_d     = pos_y_q;
            box_erase_d = 1'b0;
            state_d     = StInitDraw;
         end
         StInitDraw: if (box_done) state_d = StGap2;
         StIdle: begin
            if (req_single) begin
               if (req_off_grid) begin
                  bump_d = 1'b1;
               end else begin
                  tgt_x_d    = calc_x;
                  tgt_y_d    = calc_y;
                  rom_addr_d = calc_addr;
                  state_d    = StLookup;
               end
            end
         end
         StLookup: state_d = StWait;
         StWait:   state_d = StEval;
         StEval: begin
            if (rom_q) begin
               box_x_d     = pos_x_q;
               box_y_d     = pos_y_q;
               box_erase_d = 1'b1;
               state_d     = StErSetup;
            end else begin
               bump_d  = 1'b1;
               state_d = StIdle;
            end
         end
         StErSetup: state_d = StErRun;
         StErRun:   if (box_done) state_d = StGap1;
         StGap1: begin
            pos_x_d     = tgt_x_q;
            pos_y_d     = tgt_y_q;
            box_x_d     = tgt_x_q;
            box_y_d     = tgt_y_q;
            box_erase_d = 1'b0;
            if (move_cnt_q != 10'h3ff) move_cnt_d = move_cnt_q + 10'd1;
            state_d     = StDrSetup;
         end
         StDrSetup: state_d = StDrRun;
         StDrRun:   if (box_done) state_d = StGap2;
         StGap2: begin
            if (pos_x_q == 5'(EXIT_X) && pos_y_q == 5'(EXIT_Y)) begin
               win_d   = 1'b1;
               state_d = StWon;
            end else begin
               state_d = StIdle;
            end
         end
         StWon:   state_d = StWon;
         default: state_d = StInitSetup;
      endcase
   end

   assign box_go    = (state_q == StInitDraw) || (state_q == StErRun) || (state_q == StDrRun);
   assign busy      = (state_q != StIdle) && (state_q != StWon);
   assign box_erase = box_erase_q;
   assign box_x     = box_x_q;
   assign box_y     = box_y_q;
   assign rom_addr  = rom_addr_q;
   assign pos_x     = pos_x_q;
   assign pos_y     = pos_y_q;
   assign bump      = bump_q;
   assign win       = win_q;
   assign move_cnt  = move_cnt_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: ROM and draw-engine models, directed moves, and a
// scoreboard monitor matching draw jobs and bump pulses against queued expectations.
module tb_player_move_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] move_req;
   logic [9:0] rom_addr;
   logic       rom_q;
   logic       box_go, box_erase, box_done;
   logic [4:0] box_x, box_y, pos_x, pos_y;
   logic       busy, bump, win;
   logic [9:0] move_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit is_bump;
      bit erase;
      int x;
      int y;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;

   always #5 clk = ~clk;

   player_move_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .move_req  (move_req),
      .rom_addr  (rom_addr),
      .rom_q     (rom_q),
      .box_go    (box_go),
      .box_erase (box_erase),
      .box_x     (box_x),
      .box_y     (box_y),
      .box_done  (box_done),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .busy      (busy),
      .bump      (bump),
      .win       (win),
      .move_cnt  (move_cnt)
   );

   // Maze ROM: two-cycle latency, every cell is path except the wall at (1,2).
   logic rom_d1;
   always @(posedge clk) begin
      rom_d1 <= (rom_addr != 10'd49);
      rom_q  <= rom_d1;
   end

   // Draw engine: raises done about 81 cycles after go, clears once go drops.
   int eng_cnt;
   always @(posedge clk) begin
      if (reset || box_go !== 1'b1) begin
         eng_cnt  <= 0;
         box_done <= 1'b0;
      end else if (!box_done) begin
         if (eng_cnt == 80) box_done <= 1'b1;
         else eng_cnt <= eng_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per go rising edge and per bump pulse.
   logic       go_prev = 1'b0;
   logic [4:0] bx_prev, by_prev;
   logic       be_prev;
   always @(negedge clk) begin
      if (box_go === 1'b1 && !go_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_job: got job erase=%0d at (%0d,%0d) expected none",
                     box_erase, box_x, box_y);
         end else begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.is_bump) begin
               errors++;
               $display("FAIL event_order: got job at (%0d,%0d) expected bump", box_x, box_y);
            end else begin
               check("job_erase", box_erase, mon_e.erase);
               check("job_x", box_x, mon_e.x);
               check("job_y", box_y, mon_e.y);
               check("setup_x", bx_prev, mon_e.x);
               check("setup_y", by_prev, mon_e.y);
               check("setup_erase", be_prev, mon_e.erase);
            end
         end
      end
      if (bump === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bump: got bump at pos (%0d,%0d) expected none",
                     pos_x, pos_y);
         end else begin
            mon_e = exp_q.pop_front();
            checks++;
            if (!mon_e.is_bump) begin
               errors++;
               $display("FAIL event_order: got bump expected job at (%0d,%0d)",
                        mon_e.x, mon_e.y);
            end
         end
      end
      go_prev <= (box_go === 1'b1);
      bx_prev <= box_x;
      by_prev <= box_y;
      be_prev <= box_erase;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_job(input bit er, input int x, input int y);
      ev_t e;
      e.is_bump = 1'b0;
      e.erase   = er;
      e.x       = x;
      e.y       = y;
      exp_q.push_back(e);
   endtask

   task automatic push_bump();
      ev_t e;
      e.is_bump = 1'b1;
      e.erase   = 1'b0;
      e.x       = 0;
      e.y       = 0;
      exp_q.push_back(e);
   endtask

   task automatic req(input logic [3:0] d);
      move_req = d;
      @(negedge clk);
      move_req = 4'd0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL %s: busy still %0d after 2000 cycles, expected 0", name, busy);
      end
   endtask

   task automatic wait_go(input string name);
      int n = 0;
      while (box_go !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s: box_go still %0d after 200 cycles, expected 1", name, box_go);
      end
   endtask

   task automatic step(input logic [3:0] d, input int ox, input int oy, input int nx,
                       input int ny);
      push_job(1'b1, ox, oy);
      push_job(1'b0, nx, ny);
      req(d);
      wait_idle("step_idle");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      move_req = 4'd0;
      repeat (2) tick();
      push_job(1'b0, 0, 1);
      reset = 1'b0;
      tick();
      wait_idle("init_idle");
      check("init_busy", busy, 0);
      check("init_cnt", move_cnt, 0);
      check("init_pos_x", pos_x, 0);
      check("init_pos_y", pos_y, 1);
      check("init_win", win, 0);

      // Left from x=0 is off-grid: bump only, no ROM access.
      push_bump();
      req(4'b0100);
      repeat (4) tick();
      check("left_rom_addr", rom_addr, 0);
      check("left_busy", busy, 0);
      check("left_pos_x", pos_x, 0);

      step(4'b1000, 0, 1, 1, 1);
      check("right_pos_x", pos_x, 1);
      check("right_pos_y", pos_y, 1);
      check("right_cnt", move_cnt, 1);
      check("right_rom_addr", rom_addr, 25);
      check("right_bump", bump, 0);

      // Down into the wall at (1,2).
      push_bump();
      req(4'b0010);
      wait_idle("wall_idle");
      repeat (3) tick();
      check("wall_rom_addr", rom_addr, 49);
      check("wall_pos_y", pos_y, 1);
      check("wall_cnt", move_cnt, 1);

      // Two-hot request is ignored; a request during the erase job is dropped.
      req(4'b0101);
      repeat (4) tick();
      check("twohot_busy", busy, 0);
      push_job(1'b1, 1, 1);
      push_job(1'b0, 2, 1);
      req(4'b1000);
      wait_go("busy_go");
      repeat (3) tick();
      req(4'b0001);
      wait_idle("busy_idle");
      repeat (3) tick();
      check("busy_pos_x", pos_x, 2);
      check("busy_pos_y", pos_y, 1);
      check("busy_cnt", move_cnt, 2);

      for (int x = 2; x < 23; x++) step(4'b1000, x, 1, x + 1, 1);
      check("walk_pos_x", pos_x, 23);
      check("walk_win_early", win, 0);
      for (int y = 1; y < 22; y++) step(4'b0010, 23, y, 23, y + 1);
      check("won_win", win, 1);
      check("won_pos_y", pos_y, 22);
      check("won_cnt", move_cnt, 44);

      // In WON even an off-grid request must not bump.
      req(4'b1000);
      repeat (5) tick();
      check("won_hold_win", win, 1);
      check("won_hold_x", pos_x, 23);
      check("won_hold_busy", busy, 0);

      push_job(1'b0, 0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_win", win, 0);
      tick();
      wait_idle("rst_idle");

      // Reset in the middle of an erase job.
      push_job(1'b1, 0, 1);
      req(4'b1000);
      wait_go("mid_go");
      repeat (5) tick();
      check("mid_go_high", box_go, 1);
      push_job(1'b0, 0, 1);
      reset = 1'b1;
      tick();
      check("mid_go_drop", box_go, 0);
      check("mid_pos_x", pos_x, 0);
      check("mid_pos_y", pos_y, 1);
      check("mid_cnt", move_cnt, 0);
      reset = 1'b0;
      tick();
      wait_idle("mid_idle");
      check("mid_rom_addr", rom_addr, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Upstream controller for the 9x9 box draw engine. Accepts one-hot direction requests and checks the target cell against the maze path ROM.
- On a legal move it sequences two draw-engine jobs: erase the old cell, then draw the player sprite in the new cell.
- Tracks the player cell position, counts moves, and flags reaching the exit cell.

Parameters:
- GRID_W, 24, maze width in cells (x range 0..GRID_W-1)
- GRID_H, 24, maze height in cells (y range 0..GRID_H-1)
- START_X, 0, player x after reset
- START_Y, 1, player y after reset
- EXIT_X, 23, exit cell x
- EXIT_Y, 22, exit cell y

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- move_req  in  4  one-hot direction pulse: bit0 up, bit1 down, bit2 left, bit3 right
- rom_addr  out  10  maze ROM address, y*GRID_W+x
- rom_q  in  1  maze ROM data, 1=path, 0=wall; valid 2 cycles after rom_addr changes
- box_go  out  1  level request to draw engine; held until box_done
- box_erase  out  1  1=erase job (path colour), 0=sprite job
- box_x  out  5  cell x for the current job
- box_y  out  5  cell y for the current job
- box_done  in  1  draw engine job complete
- pos_x  out  5  current player cell x
- pos_y  out  5  current player cell y
- busy  out  1  high in every state except IDLE and WON
- bump  out  1  1-cycle pulse when a request is rejected
- win  out  1  level, high once the exit sprite is drawn
- move_cnt  out  10  accepted moves, saturates at 1023

Behaviour:
- Reset (synchronous, dominates all else):
  - box_go=0, box_erase=0, bump=0, win=0, move_cnt=0, rom_addr=0
  - pos=(START_X,START_Y), box_x/box_y=start cell
  - Next state INIT_SETUP.
- States: INIT_SETUP, INIT_DRAW, IDLE, LOOKUP, WAIT, EVAL, ER_SETUP, ER_RUN, GAP1, DR_SETUP, DR_RUN, GAP2, WON.
- Initial sprite draw:
  - INIT_SETUP: box_x/y=pos, box_erase=0, box_go=0.
  - INIT_DRAW: box_go=1 until box_done; then GAP2.
- IDLE: a move_req with exactly one bit set is accepted.
  - Compute the target cell.
  - If the target is off-grid (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down): bump=1 next cycle, stay in IDLE, no ROM access.
  - Zero bits or more than one bit set: ignored silently, no bump.
- Legal-range target:
  - LOOKUP registers rom_addr=target; then WAIT; then EVAL samples rom_q (3 cycles after acceptance).
  - rom_q=0: bump pulse, return to IDLE.
  - rom_q=1: go to ER_SETUP.
- Erase job:
  - ER_SETUP: box_x/y=old pos, box_erase=1, box_go=0. Coordinates stay stable at least 1 cycle before box_go rises, because the engine latches on the go edge.
  - ER_RUN: box_go=1 until box_done is sampled high.
  - GAP1: box_go=0 for exactly 1 cycle, which clears the engine counters. Commit pos=target and increment move_cnt (saturating) in this cycle.
- Draw job:
  - DR_SETUP: box_x/y=new pos, box_erase=0.
  - DR_RUN: box_go=1 until box_done.
  - GAP2: box_go=0. If pos==(EXIT_X,EXIT_Y), win=1 and go to WON; otherwise go to IDLE.
- move_req arriving while busy or in WON is dropped; requests are not queued.
- WON is terminal until reset; win stays high.
- box_done seen outside the RUN states is ignored.
- Reset mid-job drops box_go in the same edge. Position reverts to start; the stale sprite is not erased, because the maze redraw owns that.
- Arithmetic: rom_addr = y*GRID_W + x, computed in 10 bits. Target cell is computed in 5 bits with the off-grid check done before any decrement or increment.

Decomposition:
- Shared package maze_pkg holds:
  - GRID_W/GRID_H defaults, CELL_PITCH=10, X_OFFSET=80
  - direction bit indices (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT)
  - the state enum
- One natural sub-module: move_target_calc. It is combinational: current pos + one-hot dir -> target cell, off_grid flag, rom address.

Test Plan:
- Reset, engine model returns box_done 81 cycles after go -> one draw job at (0,1) with box_erase=0, then IDLE; busy=0, move_cnt=0.
- At (0,1), right move, ROM path at (1,1) -> rom_addr=25; erase job at (0,1), 1-cycle go gap, draw job at (1,1); pos=(1,1), move_cnt=1, bump=0.
- At (0,1), left move -> bump pulse 1 cycle later, no rom_addr change, no box_go.
- Wall at (1,2), down move from (1,1) -> rom_addr=49, bump in EVAL+1, pos unchanged, no box_go.
- move_req=4'b0101, then a request while in ER_RUN -> both ignored, no bump, single job pair.
- Step into (23,22) -> win=1 after the draw job; a further right request is ignored. Assert reset during ER_RUN of a later run -> box_go=0 next cycle, pos=(0,1).
